// File: rtl/lcd_write_arbiter.sv
// Two-requester byte arbiter driving an HD44780-style LCD over a 4-bit bus.
// Runs the power-on init sequence itself, then serves requesters round-robin.
module lcd_write_arbiter #(
   parameter int unsigned PWR_CYC   = 750000,
   parameter int unsigned SETUP_CYC = 4,
   parameter int unsigned PULSE_CYC = 12,
   parameter int unsigned HOLD_CYC  = 4,
   parameter int unsigned SHORT_CYC = 2000,
   parameter int unsigned LONG_CYC  = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic [7:0] req0_data,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic [7:0] req1_data,
   output logic       req0_ready,
   output logic       req1_ready,
   output logic       lcd_rs,
   output logic       lcd_w,
   output logic       lcd_e,
   output logic [3:0] data,
   output logic       busy,
   output logic       init_done
);

   localparam int unsigned MAX_A   = (PWR_CYC > LONG_CYC) ? PWR_CYC : LONG_CYC;
   localparam int unsigned MAX_B   = (MAX_A > SHORT_CYC) ? MAX_A : SHORT_CYC;
   localparam int unsigned MAX_C   = (MAX_B > PULSE_CYC) ? MAX_B : PULSE_CYC;
   localparam int unsigned MAX_D   = (MAX_C > SETUP_CYC) ? MAX_C : SETUP_CYC;
   localparam int unsigned MAX_CYC = (MAX_D > HOLD_CYC) ? MAX_D : HOLD_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
   localparam int unsigned IDX_W   = 3;
   localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(6);

   typedef enum logic [2:0] {
      PWR,
      INIT,
      IDLE,
      NIB_SETUP,
      NIB_PULSE,
      NIB_HOLD,
      GAP
   } state_e;

   // Terminal count for a phase of n clocks (a zero-length phase still takes one clock).
   function automatic logic [CNT_W-1:0] last_of(input int unsigned n);
      return (n == 0) ? '0 : CNT_W'(n - 1);
   endfunction

   localparam logic [CNT_W-1:0] PWR_LAST   = last_of(PWR_CYC);
   localparam logic [CNT_W-1:0] SETUP_LAST = last_of(SETUP_CYC);
   localparam logic [CNT_W-1:0] PULSE_LAST = last_of(PULSE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LAST  = last_of(HOLD_CYC);
   localparam logic [CNT_W-1:0] SHORT_LAST = last_of(SHORT_CYC);
   localparam logic [CNT_W-1:0] LONG_LAST  = last_of(LONG_CYC);

   // Init script item: {single-nibble flag, byte}; single nibbles ride in the high half.
   function automatic logic [8:0] init_item(input logic [IDX_W-1:0] idx);
      case (idx)
         3'd0:    return {1'b1, 8'h30};
         3'd1:    return {1'b1, 8'h30};
         3'd2:    return {1'b1, 8'h20};
         3'd3:    return {1'b0, 8'h28};
         3'd4:    return {1'b0, 8'h06};
         3'd5:    return {1'b0, 8'h0C};
         default: return {1'b0, 8'h01};
      endcase
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] init_idx_q, init_idx_d;
   logic [7:0]       byte_q, byte_d;
   logic             rs_q, rs_d;
   logic             lo_q, lo_d;
   logic             single_q, single_d;
   logic             long_q, long_d;
   logic             prio1_q, prio1_d;
   logic             init_done_q, init_done_d;
   logic             lcd_e_q, lcd_e_d;
   logic             lcd_rs_q, lcd_rs_d;
   logic [3:0]       data_q, data_d;
   logic             busy_q, busy_d;
   logic             gnt0_c, gnt1_c;
   logic [8:0]       item_c;

   // Round-robin grant; prio1_q set means requester 1 wins a tie.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (state_q == IDLE && init_done_q) begin
         gnt0_c = req0_valid && (!req1_valid || !prio1_q);
         gnt1_c = req1_valid && (!req0_valid || prio1_q);
      end
   end

   assign item_c = init_item(init_idx_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      init_idx_d  = init_idx_q;
      byte_d      = byte_q;
      rs_d        = rs_q;
      lo_d        = lo_q;
      single_d    = single_q;
      prio1_d     = prio1_q;
      init_done_d = init_done_q;
      lcd_rs_d    = lcd_rs_q;
      data_d      = data_q;

      case (state_q)
         PWR: begin
            if (cnt_q >= PWR_LAST) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         INIT: begin
            single_d = item_c[8];
            byte_d   = item_c[7:0];
            rs_d     = 1'b0;
            lo_d     = 1'b0;
            state_d  = NIB_SETUP;
            cnt_d    = '0;
         end
         IDLE: begin
            cnt_d = '0;
            if (gnt0_c || gnt1_c) begin
               rs_d     = gnt0_c ? req0_rs : req1_rs;
               byte_d   = gnt0_c ? req0_data : req1_data;
               prio1_d  = gnt0_c;
               single_d = 1'b0;
               lo_d     = 1'b0;
               state_d  = NIB_SETUP;
            end
         end
         NIB_SETUP: begin
            if (cnt_q >= SETUP_LAST) begin
               state_d = NIB_PULSE;
               cnt_d   = '0;
            end
         end
         NIB_PULSE: begin
            if (cnt_q >= PULSE_LAST) begin
               state_d = NIB_HOLD;
               cnt_d   = '0;
            end
         end
         NIB_HOLD: begin
            if (cnt_q >= HOLD_LAST) begin
               cnt_d = '0;
               if (lo_q || single_q) begin
                  state_d = GAP;
               end else begin
                  lo_d    = 1'b1;
                  state_d = NIB_SETUP;
               end
            end
         end
         GAP: begin
            if (cnt_q >= (long_q ? LONG_LAST : SHORT_LAST)) begin
               cnt_d = '0;
               if (init_done_q) begin
                  state_d = IDLE;
               end else if (init_idx_q == INIT_LAST) begin
                  init_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  init_idx_d = init_idx_q + IDX_W'(1);
                  state_d    = INIT;
               end
            end
         end
         default: begin
            state_d = PWR;
            cnt_d   = '0;
         end
      endcase

      // Clear-display and return-home need the long settle time.
      long_d  = single_d || (!rs_d && (byte_d == 8'h01 || byte_d == 8'h02));
      lcd_e_d = (state_d == NIB_PULSE);
      busy_d  = (state_d != IDLE);
      if (state_d == NIB_SETUP) begin
         lcd_rs_d = rs_d;
         data_d   = lo_d ? byte_d[3:0] : byte_d[7:4];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= PWR;
         cnt_q       <= '0;
         init_idx_q  <= '0;
         byte_q      <= '0;
         rs_q        <= 1'b0;
         lo_q        <= 1'b0;
         single_q    <= 1'b0;
         long_q      <= 1'b0;
         prio1_q     <= 1'b0;
         init_done_q <= 1'b0;
         lcd_e_q     <= 1'b0;
         lcd_rs_q    <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_idx_q  <= init_idx_d;
         byte_q      <= byte_d;
         rs_q        <= rs_d;
         lo_q        <= lo_d;
         single_q    <= single_d;
         long_q      <= long_d;
         prio1_q     <= prio1_d;
         init_done_q <= init_done_d;
         lcd_e_q     <= lcd_e_d;
         lcd_rs_q    <= lcd_rs_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
      end
   end

   assign req0_ready = gnt0_c;
   assign req1_ready = gnt1_c;
   assign lcd_w      = 1'b0;
   assign lcd_e      = lcd_e_q;
   assign lcd_rs     = lcd_rs_q;
   assign data       = data_q;
   assign busy       = busy_q;
   assign init_done  = init_done_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with short timing parameters.
module tb_lcd_write_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req0_rs, req1_valid, req1_rs;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       lcd_rs, lcd_w, lcd_e, busy, init_done;
   logic [3:0] data;

   always #5 clk = ~clk;

   lcd_write_arbiter #(
      .PWR_CYC(5), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1),
      .SHORT_CYC(3), .LONG_CYC(10)
   ) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .lcd_rs(lcd_rs), .lcd_w(lcd_w), .lcd_e(lcd_e), .data(data),
      .busy(busy), .init_done(init_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: nibbles at lcd_e rise, pulse widths, grants and protocol violations.
   logic       e_prev = 1'b0;
   int         e_len = 0;
   logic [3:0] nib_q[$];
   logic       rs_q[$];
   int         grant_q[$];
   int         rdy0_cnt = 0, rdy1_cnt = 0;
   int         viol_busy = 0, viol_init = 0, viol_w = 0;

   always @(negedge clk) begin
      if (lcd_e && !e_prev) begin
         nib_q.push_back(data);
         rs_q.push_back(lcd_rs);
      end
      if (lcd_e) e_len++;
      else if (e_prev) begin
         if (!reset) check("pulse_len", 64'(e_len), 64'(2));
         e_len = 0;
      end
      e_prev = lcd_e;
      if (req0_ready) rdy0_cnt++;
      if (req1_ready) rdy1_cnt++;
      if (req0_ready && req0_valid) grant_q.push_back(0);
      if (req1_ready && req1_valid) grant_q.push_back(1);
      if (busy && (req0_ready || req1_ready)) viol_busy++;
      if (!init_done && (req0_ready || req1_ready)) viol_init++;
      if (lcd_w) viol_w++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] pack_nibs();
      logic [63:0] v = '0;
      foreach (nib_q[i]) v = (v << 4) | 64'(nib_q[i]);
      return v;
   endfunction

   function automatic logic [63:0] pack_rs();
      logic [63:0] v = '0;
      foreach (rs_q[i]) v = (v << 1) | 64'(rs_q[i]);
      return v;
   endfunction

   function automatic logic [63:0] pack_grants(input int from);
      logic [63:0] v = '0;
      for (int i = from; i < grant_q.size(); i++) v = (v << 1) | 64'(grant_q[i]);
      return v;
   endfunction

   task automatic clear_mon();
      nib_q.delete();
      rs_q.delete();
   endtask

   task automatic wait_init();
      int t = 0;
      while (!init_done && t < 1000) begin
         tick();
         t++;
      end
      check("init_done", 64'(init_done), 64'(1));
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 300) begin
         tick();
         t++;
      end
      check("idle_reached", 64'(busy), 64'(0));
   endtask

   task automatic check_init_seq(input string tag);
      check({tag, "_count"}, 64'(nib_q.size()), 64'(11));
      check({tag, "_nibs"}, pack_nibs(), 64'h33228060C01);
      check({tag, "_rs"}, pack_rs(), 64'h0);
   endtask

   // Offer one byte, wait for its accept, then count busy clocks until IDLE.
   task automatic send(input bit id, input logic rs, input logic [7:0] b, output int blen);
      int t = 0;
      @(posedge clk);
      #1;
      if (id) begin req1_valid = 1'b1; req1_rs = rs; req1_data = b; end
      else    begin req0_valid = 1'b1; req0_rs = rs; req0_data = b; end
      do begin
         tick();
         t++;
      end while (!(id ? req1_ready : req0_ready) && t < 300);
      check("ready_seen", 64'(id ? req1_ready : req0_ready), 64'(1));
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      blen = 0;
      t = 0;
      while (t < 300) begin
         tick();
         t++;
         if (!busy) break;
         blen++;
      end
   endtask

   initial begin
      int blen, r0, g0, t;
      reset = 1'b1;
      req0_valid = 1'b1; req0_rs = 1'b0; req0_data = 8'h00;
      req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h00;
      repeat (3) @(posedge clk);
      tick();
      check("rst_lcd_e", 64'(lcd_e), 64'(0));
      check("rst_lcd_rs", 64'(lcd_rs), 64'(0));
      check("rst_lcd_w", 64'(lcd_w), 64'(0));
      check("rst_data", 64'(data), 64'(0));
      check("rst_busy", 64'(busy), 64'(1));
      check("rst_init_done", 64'(init_done), 64'(0));
      check("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_mon();
      wait_init();
      check_init_seq("init");
      check("idle_busy", 64'(busy), 64'(0));

      // Character 'A' from requester 0: two nibbles then a short gap.
      clear_mon();
      r0 = rdy0_cnt;
      send(1'b0, 1'b1, 8'h41, blen);
      check("a_ready_cycles", 64'(rdy0_cnt - r0), 64'(1));
      check("a_nibs", pack_nibs(), 64'h41);
      check("a_rs", pack_rs(), 64'h3);
      check("a_busy_len", 64'(blen), 64'(11));

      // Clear-display gets the long gap, set-DDRAM-address the short one.
      clear_mon();
      send(1'b1, 1'b0, 8'h01, blen);
      check("clr_busy_len", 64'(blen), 64'(18));
      send(1'b1, 1'b0, 8'h80, blen);
      check("ddram_busy_len", 64'(blen), 64'(11));
      check("cmd_nibs", pack_nibs(), 64'h0180);
      check("cmd_rs", pack_rs(), 64'h0);

      // Both requesters continuously valid: strict alternation.
      clear_mon();
      g0 = grant_q.size();
      @(posedge clk);
      #1;
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
      req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h42;
      t = 0;
      while (grant_q.size() < g0 + 4 && t < 300) begin
         tick();
         t++;
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();
      check("rr_count", 64'(grant_q.size() - g0), 64'(4));
      check("rr_order", pack_grants(g0), 64'b0101);
      check("rr_nibs", pack_nibs(), 64'h41424142);

      // Request raised while busy waits for IDLE and is taken once.
      clear_mon();
      @(posedge clk);
      #1;
      req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h80;
      t = 0;
      do begin tick(); t++; end while (!req1_ready && t < 300);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h33;
      r0 = rdy0_cnt;
      g0 = grant_q.size();
      t = 0;
      do begin tick(); t++; end while (!req0_ready && t < 300);
      check("late_wait", 64'(t), 64'(12));
      check("late_busy_at_ready", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      wait_idle();
      repeat (3) tick();
      check("late_ready_cycles", 64'(rdy0_cnt - r0), 64'(1));
      check("late_grants", pack_grants(g0), 64'b0);
      check("late_grant_count", 64'(grant_q.size() - g0), 64'(1));
      check("late_nibs", pack_nibs(), 64'h8033);

      // Reset during a user pulse aborts and replays the whole init.
      @(posedge clk);
      #1;
      req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
      t = 0;
      do begin tick(); t++; end while (!req0_ready && t < 300);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      t = 0;
      while (!lcd_e && t < 300) begin tick(); t++; end
      check("abort_pulse_seen", 64'(lcd_e), 64'(1));
      reset = 1'b1;
      req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h66;
      tick();
      check("abort_lcd_e", 64'(lcd_e), 64'(0));
      check("abort_init_done", 64'(init_done), 64'(0));
      check("abort_busy", 64'(busy), 64'(1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_mon();
      wait_init();
      check_init_seq("reinit");
      clear_mon();
      t = 0;
      while (!req1_ready && t < 300) begin tick(); t++; end
      check("post_reinit_ready", 64'(req1_ready), 64'(1));
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      wait_idle();
      check("post_reinit_nibs", pack_nibs(), 64'h66);

      check("ready_while_busy", 64'(viol_busy), 64'(0));
      check("ready_before_init", 64'(viol_init), 64'(0));
      check("lcd_w_high", 64'(viol_w), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
